// File: rtl/clint_lite_if.sv
// Data-side bus bundle for clint_lite: single-cycle request, registered one-cycle response.
interface clint_lite_if;
  logic        bus_req_i;
  logic        bus_we_i;
  logic [15:0] bus_addr_i;
  logic [3:0]  bus_be_i;
  logic [31:0] bus_wdata_i;
  logic        bus_rvalid_o;
  logic [31:0] bus_rdata_o;

  modport master (
    output bus_req_i, bus_we_i, bus_addr_i, bus_be_i, bus_wdata_i,
    input  bus_rvalid_o, bus_rdata_o
  );

  modport slave (
    input  bus_req_i, bus_we_i, bus_addr_i, bus_be_i, bus_wdata_i,
    output bus_rvalid_o, bus_rdata_o
  );
endinterface

// File: rtl/clint_lite.sv
// Core-local interrupt controller: 64-bit mtime/mtimecmp and msip behind a simple bus,
// producing the machine software and machine timer interrupt levels for the core.
module clint_lite #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  clint_lite_if.slave bus,
  output logic        irq_software_o,
  output logic        irq_timer_o
);

  localparam logic [15:0] PRE_LAST   = 16'(PRESCALE - 1);
  localparam logic [15:0] A_MSIP     = 16'h0000;
  localparam logic [15:0] A_CMP_LO   = 16'h4000;
  localparam logic [15:0] A_CMP_HI   = 16'h4004;
  localparam logic [15:0] A_TIME_LO  = 16'hBFF8;
  localparam logic [15:0] A_TIME_HI  = 16'hBFFC;

  logic [15:0] pre_cnt;
  logic        tick;
  logic [63:0] mtime;
  logic [63:0] mtimecmp;
  logic        msip;
  logic [15:0] word_addr;
  logic        wr;
  logic        rd;
  logic        sel_msip;
  logic        sel_cmp_lo;
  logic        sel_cmp_hi;
  logic        sel_time_lo;
  logic        sel_time_hi;
  logic [31:0] rd_mux;
  logic        rvalid_q;
  logic [31:0] rdata_q;
  logic        irq_timer_q;
  logic        unused_addr_lsb;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  be);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = be[i] ? new_val[8*i +: 8] : old_val[8*i +: 8];
    end
    return res;
  endfunction

  assign word_addr       = {bus.bus_addr_i[15:2], 2'b00};
  assign unused_addr_lsb = ^bus.bus_addr_i[1:0];
  assign wr              = bus.bus_req_i & bus.bus_we_i;
  assign rd              = bus.bus_req_i & ~bus.bus_we_i;
  assign sel_msip        = (word_addr == A_MSIP);
  assign sel_cmp_lo      = (word_addr == A_CMP_LO);
  assign sel_cmp_hi      = (word_addr == A_CMP_HI);
  assign sel_time_lo     = (word_addr == A_TIME_LO);
  assign sel_time_hi     = (word_addr == A_TIME_HI);
  assign tick            = (pre_cnt == PRE_LAST);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= tick ? '0 : pre_cnt + 16'd1;
    end
  end

  // A write to either mtime word takes priority over the tick for the full 64 bits.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      mtime <= '0;
    end else if (wr && (sel_time_lo || sel_time_hi)) begin
      if (sel_time_lo) mtime[31:0]  <= merge_bytes(mtime[31:0],  bus.bus_wdata_i, bus.bus_be_i);
      if (sel_time_hi) mtime[63:32] <= merge_bytes(mtime[63:32], bus.bus_wdata_i, bus.bus_be_i);
    end else if (tick) begin
      mtime <= mtime + 64'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      mtimecmp <= '1;
    end else begin
      if (wr && sel_cmp_lo) mtimecmp[31:0]  <= merge_bytes(mtimecmp[31:0],  bus.bus_wdata_i, bus.bus_be_i);
      if (wr && sel_cmp_hi) mtimecmp[63:32] <= merge_bytes(mtimecmp[63:32], bus.bus_wdata_i, bus.bus_be_i);
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      msip <= 1'b0;
    end else if (wr && sel_msip && bus.bus_be_i[0]) begin
      msip <= bus.bus_wdata_i[0];
    end
  end

  always_comb begin
    rd_mux = '0;
    case (word_addr)
      A_MSIP:    rd_mux = {31'd0, msip};
      A_CMP_LO:  rd_mux = mtimecmp[31:0];
      A_CMP_HI:  rd_mux = mtimecmp[63:32];
      A_TIME_LO: rd_mux = mtime[31:0];
      A_TIME_HI: rd_mux = mtime[63:32];
      default:   rd_mux = '0;
    endcase
  end

  // Response and compare are registered from pre-edge values, so reads never see this edge's increment.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rvalid_q    <= 1'b0;
      rdata_q     <= '0;
      irq_timer_q <= 1'b0;
    end else begin
      rvalid_q    <= bus.bus_req_i;
      rdata_q     <= rd ? rd_mux : 32'd0;
      irq_timer_q <= (mtime >= mtimecmp);
    end
  end

  assign bus.bus_rvalid_o = rvalid_q;
  assign bus.bus_rdata_o  = rdata_q;
  assign irq_software_o   = msip;
  assign irq_timer_o      = irq_timer_q;

endmodule

// File: tb/tb_clint_lite.sv
// Bench for clint_lite: two instances (PRESCALE 1 and 4) checked every cycle against a
// transaction-level model, plus directed sequences with hand-computed expectations.
module tb_clint_lite;

  typedef struct packed {
    logic [63:0] t;
    logic [63:0] c;
    logic        msip;
    logic        rvalid;
    logic [31:0] rdata;
    logic        irq_t;
  } mstate_t;

  localparam mstate_t M_RST = '{t: 64'd0, c: {64{1'b1}}, msip: 1'b0,
                                rvalid: 1'b0, rdata: 32'd0, irq_t: 1'b0};

  logic clk;
  logic rstn;
  logic irq_sw_p1, irq_tm_p1, irq_sw_p4, irq_tm_p4;
  int   n_checks = 0;
  int   n_err    = 0;
  mstate_t     ms [2];
  int unsigned m_cyc;

  clint_lite_if bus_p1 ();
  clint_lite_if bus_p4 ();

  clint_lite #(.PRESCALE(1)) dut_p1 (
    .clk_i(clk), .rstn_i(rstn), .bus(bus_p1),
    .irq_software_o(irq_sw_p1), .irq_timer_o(irq_tm_p1)
  );

  clint_lite #(.PRESCALE(4)) dut_p4 (
    .clk_i(clk), .rstn_i(rstn), .bus(bus_p4),
    .irq_software_o(irq_sw_p4), .irq_timer_o(irq_tm_p4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not end, got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Register-file view: one access per edge, read returns pre-edge contents, mtime counts
  // edges since reset in groups of p unless an mtime word is written that edge.
  function automatic mstate_t step(input mstate_t s, input int unsigned cyc, input int unsigned p,
                                   input logic req, input logic we, input logic [15:0] addr,
                                   input logic [3:0] be, input logic [31:0] wd);
    mstate_t     n;
    logic [15:0] a;
    logic        time_wr;
    n       = s;
    a       = addr & 16'hFFFC;
    time_wr = req && we && (a == 16'hBFF8 || a == 16'hBFFC);
    n.irq_t  = (s.t >= s.c);
    n.rvalid = req;
    n.rdata  = 32'd0;
    if (req && !we) begin
      case (a)
        16'h0000: n.rdata = {31'd0, s.msip};
        16'h4000: n.rdata = s.c[31:0];
        16'h4004: n.rdata = s.c[63:32];
        16'hBFF8: n.rdata = s.t[31:0];
        16'hBFFC: n.rdata = s.t[63:32];
        default:  n.rdata = 32'd0;
      endcase
    end
    if (req && we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) begin
          case (a)
            16'h0000: if (b == 0) n.msip = wd[0];
            16'h4000: n.c[8*b +: 8]      = wd[8*b +: 8];
            16'h4004: n.c[32+8*b +: 8]   = wd[8*b +: 8];
            16'hBFF8: n.t[8*b +: 8]      = wd[8*b +: 8];
            16'hBFFC: n.t[32+8*b +: 8]   = wd[8*b +: 8];
            default: ;
          endcase
        end
      end
    end
    if (!time_wr && ((cyc % p) == p - 1)) n.t = s.t + 64'd1;
    return n;
  endfunction

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ms[0] <= M_RST;
      ms[1] <= M_RST;
      m_cyc <= 0;
    end else begin
      ms[0] <= step(ms[0], m_cyc, 1, bus_p1.bus_req_i, bus_p1.bus_we_i, bus_p1.bus_addr_i,
                    bus_p1.bus_be_i, bus_p1.bus_wdata_i);
      ms[1] <= step(ms[1], m_cyc, 4, bus_p4.bus_req_i, bus_p4.bus_we_i, bus_p4.bus_addr_i,
                    bus_p4.bus_be_i, bus_p4.bus_wdata_i);
      m_cyc <= m_cyc + 1;
    end
  end

  task automatic cmp_inst(input string tag, input logic rv, input logic [31:0] rd,
                          input logic ti, input logic si, input mstate_t e);
    chk({tag, "_rvalid"}, {63'd0, rv}, {63'd0, e.rvalid});
    if (e.rvalid) chk({tag, "_rdata"}, {32'd0, rd}, {32'd0, e.rdata});
    chk({tag, "_irq_timer"}, {63'd0, ti}, {63'd0, e.irq_t});
    chk({tag, "_irq_software"}, {63'd0, si}, {63'd0, e.msip});
  endtask

  always @(negedge clk) begin
    cmp_inst("p1", bus_p1.bus_rvalid_o, bus_p1.bus_rdata_o, irq_tm_p1, irq_sw_p1, ms[0]);
    cmp_inst("p4", bus_p4.bus_rvalid_o, bus_p4.bus_rdata_o, irq_tm_p4, irq_sw_p4, ms[1]);
  end

  task automatic set_bus(input int k, input logic req, input logic we, input logic [15:0] addr,
                         input logic [3:0] be, input logic [31:0] wd);
    if (k == 0) begin
      bus_p1.bus_req_i = req; bus_p1.bus_we_i = we; bus_p1.bus_addr_i = addr;
      bus_p1.bus_be_i = be; bus_p1.bus_wdata_i = wd;
    end else begin
      bus_p4.bus_req_i = req; bus_p4.bus_we_i = we; bus_p4.bus_addr_i = addr;
      bus_p4.bus_be_i = be; bus_p4.bus_wdata_i = wd;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One access; returns the response seen just after the sampling edge.
  task automatic acc(input int k, input logic we, input logic [15:0] addr, input logic [3:0] be,
                     input logic [31:0] wd, output logic [31:0] rd, output logic rv);
    set_bus(k, 1'b1, we, addr, be, wd);
    @(posedge clk);
    #1;
    rd = (k == 0) ? bus_p1.bus_rdata_o  : bus_p4.bus_rdata_o;
    rv = (k == 0) ? bus_p1.bus_rvalid_o : bus_p4.bus_rvalid_o;
    set_bus(k, 1'b0, 1'b0, 16'h0, 4'h0, 32'h0);
  endtask

  logic [31:0] rd, v0, v1;
  logic        rv;
  logic [31:0] seq_v [3];
  logic [15:0] ra;
  logic [31:0] rwd;

  initial begin
    rstn = 1'b0;
    set_bus(0, 1'b0, 1'b0, 16'h0, 4'h0, 32'h0);
    set_bus(1, 1'b0, 1'b0, 16'h0, 4'h0, 32'h0);
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;

    // Reset state: three edges after release mtime holds 3.
    idle(3);
    acc(0, 1'b0, 16'hBFF8, 4'h0, 32'h0, rd, rv); chk("reset_mtime_lo", rd, 32'd3);
    acc(0, 1'b0, 16'h0000, 4'h0, 32'h0, rd, rv); chk("reset_msip", rd, 32'd0);
    acc(0, 1'b0, 16'h4000, 4'h0, 32'h0, rd, rv); chk("reset_cmp_lo", rd, 32'hFFFF_FFFF);
    acc(0, 1'b0, 16'h4004, 4'h0, 32'h0, rd, rv); chk("reset_cmp_hi", rd, 32'hFFFF_FFFF);
    acc(0, 1'b0, 16'hBFFC, 4'h0, 32'h0, rd, rv); chk("reset_mtime_hi", rd, 32'd0);
    chk("reset_irq_timer", {63'd0, irq_tm_p1}, 64'd0);
    chk("reset_irq_sw", {63'd0, irq_sw_p1}, 64'd0);

    // msip byte-enable behaviour
    acc(0, 1'b1, 16'h0000, 4'h2, 32'h1, rd, rv); chk("msip_be2_nochange", {63'd0, irq_sw_p1}, 64'd0);
    acc(0, 1'b1, 16'h0000, 4'h1, 32'h1, rd, rv); chk("msip_set", {63'd0, irq_sw_p1}, 64'd1);
    chk("write_rvalid", {63'd0, rv}, 64'd1);
    chk("write_rdata_zero", rd, 32'd0);
    acc(0, 1'b1, 16'h0000, 4'hF, 32'h0, rd, rv); chk("msip_clear", {63'd0, irq_sw_p1}, 64'd0);

    // Timer fire at mtime == 20 and release after raising mtimecmp
    acc(0, 1'b1, 16'h4004, 4'hF, 32'd0,  rd, rv);
    acc(0, 1'b1, 16'h4000, 4'hF, 32'd20, rd, rv);
    acc(0, 1'b1, 16'hBFF8, 4'hF, 32'd0,  rd, rv);
    acc(0, 1'b1, 16'hBFFC, 4'hF, 32'd0,  rd, rv);
    idle(20); chk("timer_before_fire", {63'd0, irq_tm_p1}, 64'd0);
    idle(1);  chk("timer_fire", {63'd0, irq_tm_p1}, 64'd1);
    acc(0, 1'b1, 16'h4000, 4'hF, 32'd100, rd, rv); chk("timer_hold_one_edge", {63'd0, irq_tm_p1}, 64'd1);
    idle(1);  chk("timer_release", {63'd0, irq_tm_p1}, 64'd0);

    // Carry into the upper word
    acc(0, 1'b1, 16'hBFFC, 4'hF, 32'd0, rd, rv);
    acc(0, 1'b1, 16'hBFF8, 4'hF, 32'hFFFF_FFFF, rd, rv);
    idle(1);
    acc(0, 1'b0, 16'hBFF8, 4'h0, 32'h0, rd, rv); chk("carry_lo", rd, 32'd0);
    acc(0, 1'b0, 16'hBFFC, 4'h0, 32'h0, rd, rv); chk("carry_hi", rd, 32'd1);

    // Full 64-bit wrap
    acc(0, 1'b1, 16'hBFFC, 4'hF, 32'hFFFF_FFFF, rd, rv);
    acc(0, 1'b1, 16'hBFF8, 4'hF, 32'hFFFF_FFFF, rd, rv);
    acc(0, 1'b0, 16'hBFF8, 4'h0, 32'h0, rd, rv); chk("wrap_lo_before", rd, 32'hFFFF_FFFF);
    acc(0, 1'b0, 16'hBFFC, 4'h0, 32'h0, rd, rv); chk("wrap_hi_after", rd, 32'd0);

    // Unmapped read, then back-to-back reads of mtime lo
    acc(0, 1'b0, 16'h1234, 4'h0, 32'h0, rd, rv);
    chk("unmapped_rdata", rd, 32'd0);
    chk("unmapped_rvalid", {63'd0, rv}, 64'd1);
    for (int i = 0; i < 3; i++) begin
      acc(0, 1'b0, 16'hBFF8, 4'h0, 32'h0, seq_v[i], rv);
      chk("b2b_rvalid", {63'd0, rv}, 64'd1);
    end
    chk("b2b_step1", {32'd0, seq_v[1]}, {32'd0, seq_v[0] + 32'd1});
    chk("b2b_step2", {32'd0, seq_v[2]}, {32'd0, seq_v[0] + 32'd2});

    // PRESCALE=4: 100 edges give 25 increments; a write on a tick edge keeps the written value
    acc(1, 1'b0, 16'hBFF8, 4'h0, 32'h0, v0, rv);
    idle(99);
    acc(1, 1'b0, 16'hBFF8, 4'h0, 32'h0, v1, rv);
    chk("prescale_rate", {32'd0, v1 - v0}, 64'd25);
    while ((m_cyc % 4) != 3) idle(1);
    acc(1, 1'b1, 16'hBFF8, 4'hF, 32'h55, rd, rv);
    acc(1, 1'b0, 16'hBFF8, 4'h0, 32'h0, rd, rv); chk("tick_write_hold", rd, 32'h55);

    // Random traffic on both instances, checked by the model every cycle
    for (int it = 0; it < 800; it++) begin
      for (int k = 0; k < 2; k++) begin
        case ($urandom_range(0, 7))
          0: ra = 16'h0000;
          1: ra = 16'h4000;
          2: ra = 16'h4004;
          3, 7: ra = 16'hBFF8;
          4: ra = 16'hBFFC;
          5: ra = 16'($urandom);
          default: ra = 16'h0004;
        endcase
        ra[1:0] = 2'($urandom);
        if (ra[2] && ($urandom_range(0, 3) != 0)) rwd = 32'd0;
        else if (ra[2]) rwd = $urandom;
        else rwd = 32'($urandom_range(0, 400));
        set_bus(k, $urandom_range(0, 3) != 0, 1'($urandom), ra,
                ($urandom_range(0, 1) != 0) ? 4'hF : 4'($urandom), rwd);
      end
      idle(1);
    end
    set_bus(0, 1'b0, 1'b0, 16'h0, 4'h0, 32'h0);
    set_bus(1, 1'b0, 1'b0, 16'h0, 4'h0, 32'h0);
    idle(2);

    // Asynchronous reset in the middle of an access drops the response
    acc(0, 1'b1, 16'h0000, 4'h1, 32'h1, rd, rv);
    set_bus(0, 1'b1, 1'b0, 16'hBFF8, 4'h0, 32'h0);
    #3 rstn = 1'b0;
    #1;
    chk("async_rst_rvalid", {63'd0, bus_p1.bus_rvalid_o}, 64'd0);
    chk("async_rst_msip", {63'd0, irq_sw_p1}, 64'd0);
    set_bus(0, 1'b0, 1'b0, 16'h0, 4'h0, 32'h0);
    idle(2);
    rstn = 1'b1;
    idle(2);
    acc(0, 1'b0, 16'hBFF8, 4'h0, 32'h0, rd, rv); chk("post_reset_mtime", rd, 32'd2);
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
